sge_threshold_monitor: RTL and testbench

//  Downstream consumer of the signed >= comparator stage. Samples a signed value

---
 rtl/sge_threshold_monitor.sv | 116 +++++++++++
 tb/tb_sge_threshold_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sge_threshold_monitor.sv
// Debounces a signed I >= THRESH compare over valid beats into ALARM.
// Also produces registered RISE/FALL pulses and a saturating count of rising events.
module sge_threshold_monitor #(
    parameter int WIDTH     = 4,
    parameter int DEBOUNCE  = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     I,
    input  logic [WIDTH-1:0]     THRESH,
    input  logic                 I_VALID,
    output logic                 GE,
    output logic                 ALARM,
    output logic                 RISE,
    output logic                 FALL,
    output logic [CNT_WIDTH-1:0] COUNT
);
    localparam int RUN_W = $clog2(DEBOUNCE + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE);

    typedef enum logic [1:0] {LOW, ARMING, HIGH, DISARM} state_t;

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             ge;
    logic [RUN_W-1:0] run_inc;
    logic             run_done;

    // Overflow-corrected sign of the difference gives an exact full-range compare.
    assign diff     = I - THRESH;
    assign ovf      = (I[WIDTH-1] != THRESH[WIDTH-1]) && (diff[WIDTH-1] != I[WIDTH-1]);
    assign ge       = ~(diff[WIDTH-1] ^ ovf);
    assign run_inc  = run + RUN_W'(1);
    assign run_done = (run_inc == RUN_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= LOW;
            run   <= '0;
            GE    <= 1'b0;
            ALARM <= 1'b0;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
            COUNT <= '0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            if (I_VALID) begin
                GE <= ge;
                case (state)
                    LOW: begin
                        if (ge) begin
                            run <= RUN_W'(1);
                            if (DEBOUNCE == 1) begin
                                state <= HIGH;
                                ALARM <= 1'b1;
                                RISE  <= 1'b1;
                                if (COUNT != '1) COUNT <= COUNT + CNT_WIDTH'(1);
                            end else begin
                                state <= ARMING;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ARMING: begin
                        if (!ge) begin
                            state <= LOW;
                            run   <= '0;
                        end else if (run_done) begin
                            state <= HIGH;
                            run   <= '0;
                            ALARM <= 1'b1;
                            RISE  <= 1'b1;
                            if (COUNT != '1) COUNT <= COUNT + CNT_WIDTH'(1);
                        end else begin
                            run <= run_inc;
                        end
                    end
                    HIGH: begin
                        if (!ge) begin
                            run <= RUN_W'(1);
                            if (DEBOUNCE == 1) begin
                                state <= LOW;
                                ALARM <= 1'b0;
                                FALL  <= 1'b1;
                            end else begin
                                state <= DISARM;
                            end
                        end
                    end
                    DISARM: begin
                        if (ge) begin
                            state <= HIGH;
                            run   <= '0;
                        end else if (run_done) begin
                            state <= LOW;
                            run   <= '0;
                            ALARM <= 1'b0;
                            FALL  <= 1'b1;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    default: begin
                        state <= LOW;
                        run   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sge_threshold_monitor.sv
// Bench for sge_threshold_monitor: vector table, directed corner sequences, random vs model.
module tb_sge_threshold_monitor;
    localparam int DEB = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] I = '0;
    logic [3:0] THRESH = '0;
    logic       I_VALID = 1'b0;
    logic       GE, ALARM, RISE, FALL;
    logic [7:0] COUNT;
    logic       GE2, ALARM2, RISE2, FALL2;
    logic [1:0] COUNT2;

    always #5 CLK = ~CLK;

    sge_threshold_monitor #(.WIDTH(4), .DEBOUNCE(DEB), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .I(I), .THRESH(THRESH), .I_VALID(I_VALID),
        .GE(GE), .ALARM(ALARM), .RISE(RISE), .FALL(FALL), .COUNT(COUNT));

    sge_threshold_monitor #(.WIDTH(4), .DEBOUNCE(DEB), .CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .I(I), .THRESH(THRESH), .I_VALID(I_VALID),
        .GE(GE2), .ALARM(ALARM2), .RISE(RISE2), .FALL(FALL2), .COUNT(COUNT2));

    int checks = 0;
    int failures = 0;

    // Reference: alarm flips once DEB consecutive valid samples disagree with it.
    bit m_ge, m_alarm, m_rise, m_fall;
    int m_streak, m_count, m_count2;

    typedef struct {
        bit rst; int i; int th; bit v;
        bit ge; bit alarm; bit rise; bit fall; int count;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input int i, input int th, input bit v);
        @(negedge CLK);
        RESET = rst; I = 4'(i); THRESH = 4'(th); I_VALID = v;
        @(posedge CLK);
        m_rise = 0; m_fall = 0;
        if (rst) begin
            m_ge = 0; m_alarm = 0; m_streak = 0; m_count = 0; m_count2 = 0;
        end else if (v) begin
            m_ge = (i >= th);
            if (m_ge != m_alarm) m_streak++; else m_streak = 0;
            if (m_streak == DEB) begin
                m_alarm = !m_alarm;
                m_streak = 0;
                if (m_alarm) begin
                    m_rise = 1;
                    if (m_count < 255) m_count++;
                    if (m_count2 < 3) m_count2++;
                end else begin
                    m_fall = 1;
                end
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ge"}, 32'(GE), 32'(m_ge));
        chk({tag, ".alarm"}, 32'(ALARM), 32'(m_alarm));
        chk({tag, ".rise"}, 32'(RISE), 32'(m_rise));
        chk({tag, ".fall"}, 32'(FALL), 32'(m_fall));
        chk({tag, ".count"}, 32'(COUNT), 32'(m_count));
        chk({tag, ".alarm2"}, 32'(ALARM2), 32'(m_alarm));
        chk({tag, ".count2"}, 32'(COUNT2), 32'(m_count2));
    endtask

    initial begin
        vec_t vecs[$];
        int   rise_cnt, fall_cnt;
        int   exp2[4];
        int   th;

        // Boundary compares, then a broken run (1,1,0,1,1), then a clean 3-sample arm.
        vecs = '{
            '{1,  0,  0, 0, 0, 0, 0, 0, 0},
            '{0,  7, -8, 1, 1, 0, 0, 0, 0},
            '{0, -8,  7, 1, 0, 0, 0, 0, 0},
            '{0, -1, -1, 1, 1, 0, 0, 0, 0},
            '{0, -2, -1, 1, 0, 0, 0, 0, 0},
            '{0,  0, -1, 1, 1, 0, 0, 0, 0},
            '{1,  0,  0, 0, 0, 0, 0, 0, 0},
            '{0,  3,  2, 1, 1, 0, 0, 0, 0},
            '{0,  3,  2, 1, 1, 0, 0, 0, 0},
            '{0,  1,  2, 1, 0, 0, 0, 0, 0},
            '{0,  2,  2, 1, 1, 0, 0, 0, 0},
            '{0,  5, -3, 1, 1, 0, 0, 0, 0},
            '{1,  0,  0, 0, 0, 0, 0, 0, 0},
            '{0,  3,  2, 1, 1, 0, 0, 0, 0},
            '{0,  3,  2, 1, 1, 0, 0, 0, 0},
            '{0,  3,  2, 1, 1, 1, 1, 0, 1},
            '{0,  0,  0, 0, 1, 1, 0, 0, 1}
        };
        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].i, vecs[k].th, vecs[k].v);
            chk($sformatf("vec%0d.ge", k), 32'(GE), 32'(vecs[k].ge));
            chk($sformatf("vec%0d.alarm", k), 32'(ALARM), 32'(vecs[k].alarm));
            chk($sformatf("vec%0d.rise", k), 32'(RISE), 32'(vecs[k].rise));
            chk($sformatf("vec%0d.fall", k), 32'(FALL), 32'(vecs[k].fall));
            chk($sformatf("vec%0d.count", k), 32'(COUNT), 32'(vecs[k].count));
        end

        // Gaps between valid samples do not break a run.
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 4, 1, 1);
            chk($sformatf("gap.alarm%0d", k), 32'(ALARM), 32'(k == 2));
            chk($sformatf("gap.rise%0d", k), 32'(RISE), 32'(k == 2));
            for (int g = 0; g < 2; g++) begin
                step(0, -8, 7, 0);
                chk("gap.hold_ge", 32'(GE), 32'(1));
                chk("gap.hold_rise", 32'(RISE), 32'(0));
            end
        end
        fall_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(0, -3, 0, 1);
            if (FALL) fall_cnt++;
            chk($sformatf("gap.fall_alarm%0d", k), 32'(ALARM), 32'(k != 2));
        end
        step(0, 0, 0, 0);
        if (FALL) fall_cnt++;
        chk("gap.fall_pulses", 32'(fall_cnt), 32'(1));

        // Narrow counter saturates: 1,2,3,3.
        exp2 = '{1, 2, 3, 3};
        step(1, 0, 0, 0);
        rise_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) step(0, 2, 2, 1);
            if (RISE2) rise_cnt++;
            chk($sformatf("sat.count2_%0d", c), 32'(COUNT2), 32'(exp2[c]));
            for (int k = 0; k < 3; k++) step(0, 1, 2, 1);
            chk($sformatf("sat.alarm2_low%0d", c), 32'(ALARM2), 32'(0));
        end
        chk("sat.rises", 32'(rise_cnt), 32'(4));
        chk("sat.count8", 32'(COUNT), 32'(4));

        // Reset with valid high, from ARMING and from HIGH.
        for (int phase = 0; phase < 2; phase++) begin
            step(1, 0, 0, 0);
            for (int k = 0; k < 2 + phase; k++) step(0, 6, 0, 1);
            step(1, 6, 0, 1);
            chk($sformatf("rst%0d.ge", phase), 32'(GE), 32'(0));
            chk($sformatf("rst%0d.alarm", phase), 32'(ALARM), 32'(0));
            chk($sformatf("rst%0d.rise", phase), 32'(RISE), 32'(0));
            chk($sformatf("rst%0d.fall", phase), 32'(FALL), 32'(0));
            chk($sformatf("rst%0d.count", phase), 32'(COUNT), 32'(0));
            for (int k = 0; k < 3; k++) begin
                step(0, 6, 0, 1);
                chk($sformatf("rst%0d.rearm%0d", phase, k), 32'(ALARM), 32'(k == 2));
            end
        end

        // Random traffic against the reference model; threshold drifts mid-run.
        step(1, 0, 0, 0);
        th = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) th = int'($urandom_range(0, 15)) - 8;
            step($urandom_range(0, 199) == 0, int'($urandom_range(0, 15)) - 8, th,
                 $urandom_range(0, 3) != 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
